// File: rtl/pipeline_trace_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_trace_buffer_pkg
// Description : Shared constants and helpers for the retirement trace buffer.
//               Holds the default depth, the entry/drop-counter widths and a
//               ceil-log2 helper used to size pointers and the entry count.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_trace_buffer_pkg;

    localparam int TRACE_DEPTH_DEFAULT = 16;
    localparam int TRACE_ENTRY_W       = 64;   // {PC, write-back data}
    localparam int DROP_CNT_W          = 16;

    // Ceil-log2: number of bits needed to index 'value' entries.
    function automatic int traceClog2(input int value);
        int width;
        width = 0;
        while ((1 << width) < value) begin
            width = width + 1;
        end
        return width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_trace_buffer_trace_fifo.sv
`default_nettype none
// ============================================================================
// Module      : trace_fifo
// Description : Show-ahead synchronous FIFO. The head entry is presented on
//               rdData combinationally from storage; push and pop may occur
//               in the same cycle, including a push into a full FIFO that is
//               popped at the same edge.
// Ports       : Clk, Reset (sync, active-low)
//               push / wrData   - write request and entry
//               pop             - remove head (ignored while empty)
//               rdData          - head entry (zero while empty)
//               count/full/empty- occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
module trace_fifo
    import pipeline_trace_buffer_pkg::*;
#(
    parameter int DEPTH = TRACE_DEPTH_DEFAULT,
    parameter int WIDTH = TRACE_ENTRY_W
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wrData,
    input  logic                         pop,
    output logic [WIDTH-1:0]             rdData,
    output logic [traceClog2(DEPTH):0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int               PTR_W  = traceClog2(DEPTH);
    localparam logic [PTR_W:0]   c_FULL = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [PTR_W:0]   r_count;

    logic w_doPush;
    logic w_doPop;

    assign empty    = (r_count == '0);
    assign full     = (r_count == c_FULL);
    assign w_doPop  = pop && !empty;
    // A full FIFO can still accept a push when the head leaves at this edge.
    assign w_doPush = push && (!full || w_doPop);

    assign count  = r_count;
    // Gate the head while empty so the outputs read zero after reset even
    // though storage itself is never cleared.
    assign rdData = empty ? '0 : r_mem[r_rdPtr];

    always_ff @(posedge Clk) begin
        if (Reset && w_doPush) begin
            r_mem[r_wrPtr] <= wrData;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipeline_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_trace_buffer
// Description : Retirement trace capture for the pipelined MIPS core. Records
//               {PC, write-back data} whenever the PC changes (or on the first
//               enabled sample), buffers records in a show-ahead FIFO drained
//               over valid/ready, and flags/counts drops instead of stalling.
// Ports       : Clk, Reset (sync, active-low)
//               PCResult, WriteDataReg, CaptureEn - core sample inputs
//               TraceValid, TraceReady, TracePC, TraceData - consumer side
//               Count     - entries stored (0..DEPTH)
//               Overflow  - sticky drop flag
//               DropCount - dropped records, saturating
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_trace_buffer
    import pipeline_trace_buffer_pkg::*;
#(
    parameter int DEPTH = TRACE_DEPTH_DEFAULT
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic [31:0]                 PCResult,
    input  logic [31:0]                 WriteDataReg,
    input  logic                        CaptureEn,
    output logic                        TraceValid,
    input  logic                        TraceReady,
    output logic [31:0]                 TracePC,
    output logic [31:0]                 TraceData,
    output logic [traceClog2(DEPTH):0]  Count,
    output logic                        Overflow,
    output logic [DROP_CNT_W-1:0]       DropCount
);

    logic [31:0]              r_lastPC;
    logic                     r_haveLast;
    logic                     r_overflow;
    logic [DROP_CNT_W-1:0]    r_dropCount;

    logic                     w_qualify;
    logic                     w_pop;
    logic                     w_push;
    logic                     w_drop;
    logic                     w_full;
    logic                     w_empty;
    logic [TRACE_ENTRY_W-1:0] w_head;

    // A stalled core holds its PC, so only a PC change produces a new record.
    assign w_qualify = CaptureEn && (!r_haveLast || (PCResult != r_lastPC));
    assign w_pop     = !w_empty && TraceReady;
    assign w_push    = w_qualify && (!w_full || w_pop);
    assign w_drop    = w_qualify && w_full && !w_pop;

    trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (TRACE_ENTRY_W)
    ) u_fifo (
        .Clk    (Clk),
        .Reset  (Reset),
        .push   (w_push),
        .wrData ({PCResult, WriteDataReg}),
        .pop    (w_pop),
        .rdData (w_head),
        .count  (Count),
        .full   (w_full),
        .empty  (w_empty)
    );

    assign TraceValid = !w_empty;
    assign TracePC    = w_head[TRACE_ENTRY_W-1:32];
    assign TraceData  = w_head[31:0];
    assign Overflow   = r_overflow;
    assign DropCount  = r_dropCount;

    // LastPC tracks every qualifying sample, stored or dropped.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_lastPC   <= '0;
            r_haveLast <= 1'b0;
        end else if (w_qualify) begin
            r_lastPC   <= PCResult;
            r_haveLast <= 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_overflow  <= 1'b0;
            r_dropCount <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_dropCount != '1) begin
                r_dropCount <= r_dropCount + DROP_CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_trace_buffer
// Description : Self-checking bench for pipeline_trace_buffer. A reference
//               model decides which samples qualify, pushes expected records
//               into a scoreboard queue and pops them as the consumer
//               handshake takes the head.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_trace_buffer;

    localparam int DEPTH = 16;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] PCResult;
    logic [31:0] WriteDataReg;
    logic        CaptureEn;
    logic        TraceValid;
    logic        TraceReady;
    logic [31:0] TracePC;
    logic [31:0] TraceData;
    logic [4:0]  Count;
    logic        Overflow;
    logic [15:0] DropCount;

    always #5 Clk = ~Clk;

    pipeline_trace_buffer #(.DEPTH(DEPTH)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .PCResult     (PCResult),
        .WriteDataReg (WriteDataReg),
        .CaptureEn    (CaptureEn),
        .TraceValid   (TraceValid),
        .TraceReady   (TraceReady),
        .TracePC      (TracePC),
        .TraceData    (TraceData),
        .Count        (Count),
        .Overflow     (Overflow),
        .DropCount    (DropCount)
    );

    int          vectors     = 0;
    int          miscompares = 0;

    logic [63:0] sb[$];
    bit          mHaveLast;
    logic [31:0] mLastPC;
    bit          mOverflow;
    int          mDrop;

    task automatic checkValue(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Entered at a negedge; drives one sample, checks head before the edge
    // and status after it, and returns at the following negedge.
    task automatic cycle(input bit cap, input logic [31:0] pc,
                         input logic [31:0] data, input bit rdy);
        bit pop;
        bit qual;
        bit full;
        CaptureEn    = cap;
        PCResult     = pc;
        WriteDataReg = data;
        TraceReady   = rdy;
        #1;
        checkValue("valid", {63'd0, TraceValid}, {63'd0, sb.size() != 0});
        if (sb.size() != 0) begin
            checkValue("headPC",   {32'd0, TracePC},   {32'd0, sb[0][63:32]});
            checkValue("headData", {32'd0, TraceData}, {32'd0, sb[0][31:0]});
        end
        full = (sb.size() == DEPTH);
        pop  = (sb.size() != 0) && rdy;
        qual = cap && (!mHaveLast || pc != mLastPC);
        if (pop) void'(sb.pop_front());
        if (qual) begin
            mHaveLast = 1'b1;
            mLastPC   = pc;
            if (!full || pop) begin
                sb.push_back({pc, data});
            end else begin
                mOverflow = 1'b1;
                if (mDrop < 65535) mDrop++;
            end
        end
        @(posedge Clk);
        #1;
        checkValue("count",     {59'd0, Count},     64'(sb.size()));
        checkValue("overflow",  {63'd0, Overflow},  {63'd0, mOverflow});
        checkValue("dropCount", {48'd0, DropCount}, 64'(mDrop));
        @(negedge Clk);
    endtask

    // Reset with capture and ready active to show both are ignored.
    task automatic doReset();
        Reset        = 1'b0;
        CaptureEn    = 1'b1;
        TraceReady   = 1'b1;
        PCResult     = 32'hDEAD_0000;
        WriteDataReg = 32'h1234_5678;
        @(posedge Clk);
        #1;
        sb.delete();
        mHaveLast = 1'b0;
        mLastPC   = '0;
        mOverflow = 1'b0;
        mDrop     = 0;
        checkValue("rstCount",    {59'd0, Count},      64'd0);
        checkValue("rstValid",    {63'd0, TraceValid}, 64'd0);
        checkValue("rstOverflow", {63'd0, Overflow},   64'd0);
        checkValue("rstDrop",     {48'd0, DropCount},  64'd0);
        checkValue("rstPC",       {32'd0, TracePC},    64'd0);
        checkValue("rstData",     {32'd0, TraceData},  64'd0);
        @(negedge Clk);
        Reset = 1'b1;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 32'h0, 1'b1);
    endtask

    initial begin
        logic [31:0] savedPC;
        Reset        = 1'b0;
        CaptureEn    = 1'b0;
        TraceReady   = 1'b0;
        PCResult     = '0;
        WriteDataReg = '0;
        @(negedge Clk);
        doReset();

        // Stepping PC with the consumer always ready.
        cycle(1'b1, 32'h0, 32'hA0, 1'b1);
        cycle(1'b1, 32'h4, 32'hA1, 1'b1);
        cycle(1'b1, 32'h8, 32'hA2, 1'b1);
        drain(2);

        // Stalled core: constant PC yields one record.
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'h10, 32'hB0 + 32'(i), 1'b0);
        checkValue("stallCount", {59'd0, Count}, 64'd1);
        drain(2);

        // Overflow: 18 distinct PCs with no consumer.
        for (int i = 0; i < 18; i++) cycle(1'b1, 32'h100 + 32'(4 * i), 32'hC00 + 32'(i), 1'b0);
        checkValue("fullCount", {59'd0, Count},     64'd16);
        checkValue("fullOvf",   {63'd0, Overflow},  64'd1);
        checkValue("fullDrop",  {48'd0, DropCount}, 64'd2);
        // Full with coincident pop: push accepted.
        cycle(1'b1, 32'h300, 32'hD00, 1'b1);
        checkValue("fullPopCount", {59'd0, Count},     64'd16);
        checkValue("fullPopDrop",  {48'd0, DropCount}, 64'd2);
        drain(17);

        // Reset mid-operation with 7 entries and Overflow set.
        for (int i = 0; i < 7; i++) cycle(1'b1, 32'h400 + 32'(4 * i), 32'hE00 + 32'(i), 1'b0);
        savedPC = mLastPC;
        checkValue("preRstCount", {59'd0, Count}, 64'd7);
        doReset();
        cycle(1'b1, savedPC, 32'hF00, 1'b0);
        checkValue("postRstCapture", {59'd0, Count}, 64'd1);
        drain(2);

        // CaptureEn low: no pushes; then re-enable at same and new PC.
        for (int i = 0; i < 4; i++) cycle(1'b0, 32'h500 + 32'(4 * i), 32'h1, 1'b0);
        cycle(1'b1, savedPC, 32'h2, 1'b0);
        cycle(1'b1, 32'h600, 32'h3, 1'b0);
        drain(2);

        // Mixed random traffic.
        for (int i = 0; i < 80; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 32'h700 + 32'(4 * $urandom_range(0, 3)),
                  $urandom, 1'($urandom_range(0, 2) == 0));
        end
        drain(DEPTH + 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
